// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and the trace record type used by the writeback trace buffer.
//   XLEN         - data/PC width
//   REG_AW       - register index width
//   TRACE_DROP_W - width of the saturating drop counter
//   trace_rec_t  - one captured commit {pc, rd, value[, ts]}
// Optional: WB_TRACE_TS_EN adds a capture timestamp field to trace_rec_t.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int TRACE_DROP_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;     // destination register ('reg' is a keyword)
    logic [XLEN-1:0]   value;
`ifdef WB_TRACE_TS_EN
    logic [XLEN-1:0]   ts;     // free-running cycle count at capture
`endif
  } trace_rec_t;

endpackage

// File: rtl/wb_trace_buffer_trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Generic synchronous FIFO, register-array storage, MSB-wrap pointers.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   flush           - synchronous clear; overrides push/pop
//   push, wr_data   - write request (caller guarantees room or same-cycle pop)
//   pop             - read request (caller guarantees non-empty)
//   rd_data         - head entry (combinational from storage)
//   full, empty     - occupancy flags
//   level           - current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, and leaving the array unreset lets it map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Full-with-pop writes into the slot being read this cycle; the read sees the
  // old entry, the write lands at the edge.
  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
// Captures qualifying CPU register-writeback commits into a FIFO and drains
// them to a trace sink over a valid/ready stream, with commit/drop/high-water
// statistics.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   trace_en                  - capture enable (level)
//   flush                     - one-cycle synchronous clear
//   wb_have_inst/ena/pc/reg/value - CPU writeback debug inputs
//   out_valid/ready/pc/reg/value  - head-of-FIFO stream to the sink
//   level, high_water         - occupancy and its maximum since reset/flush
//   commit_cnt                - qualifying commits seen (wraps)
//   drop_cnt, overflow        - commits lost to a full FIFO (saturating), sticky flag
// Optional (macro WB_TRACE_TS_EN): out_ts, head entry's capture cycle.
// -----------------------------------------------------------------------------
module wb_trace_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int SKIP_X0 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trace_en,
  input  logic                    flush,
  input  logic                    wb_have_inst,
  input  logic                    wb_ena,
  input  logic [XLEN-1:0]         wb_pc,
  input  logic [REG_AW-1:0]       wb_reg,
  input  logic [XLEN-1:0]         wb_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [REG_AW-1:0]       out_reg,
  output logic [XLEN-1:0]         out_value,
  output logic [AW:0]             level,
  output logic [AW:0]             high_water,
  output logic [31:0]             commit_cnt,
  output logic [TRACE_DROP_W-1:0] drop_cnt,
  output logic                    overflow
`ifdef WB_TRACE_TS_EN
  ,
  output logic [XLEN-1:0]         out_ts
`endif
);

  trace_rec_t wr_rec, rd_rec, head_rec;
  logic       qualify, push, pop, drop, full, empty;
  logic [AW:0] level_d;

  logic [AW:0]             high_water_q, high_water_d;
  logic [31:0]             commit_cnt_q, commit_cnt_d;
  logic [TRACE_DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                    overflow_q, overflow_d;

  assign qualify = trace_en && wb_have_inst && wb_ena &&
                   !((SKIP_X0 != 0) && (wb_reg == '0));
  assign pop     = out_valid && out_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push    = qualify && (!full || pop);
  assign drop    = qualify && full && !pop && !flush;

`ifdef WB_TRACE_TS_EN
  logic [XLEN-1:0] ts_q, ts_d;
  assign ts_d = ts_q + 1'b1;   // free-running; flush deliberately leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`endif

  always_comb begin
    wr_rec       = '0;
    wr_rec.pc    = wb_pc;
    wr_rec.rd    = wb_reg;
    wr_rec.value = wb_value;
`ifdef WB_TRACE_TS_EN
    wr_rec.ts    = ts_q;
`endif
  end

  trace_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (rd_rec),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Head fields read as zero while empty, so reset forces out_* to 0 at once
  // without resetting the storage.
  assign head_rec  = empty ? '0 : rd_rec;
  assign out_valid = !empty;
  assign out_pc    = head_rec.pc;
  assign out_reg   = head_rec.rd;
  assign out_value = head_rec.value;
`ifdef WB_TRACE_TS_EN
  assign out_ts    = head_rec.ts;
`endif

  always_comb begin
    level_d      = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    commit_cnt_d = commit_cnt_q + {31'd0, qualify};  // counted even when flushed
    high_water_d = high_water_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    if (flush) begin
      level_d      = '0;
      high_water_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      if (level_d > high_water_q) high_water_d = level_d;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_water_q <= '0;
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      high_water_q <= high_water_d;
      commit_cnt_q <= commit_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign high_water = high_water_q;
  assign commit_cnt = commit_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_buffer
// Directed self-checking bench for wb_trace_buffer (DEPTH=16, SKIP_X0=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that
// same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_en, flush, wb_have_inst, wb_ena, out_ready;
  logic [31:0] wb_pc, wb_value;
  logic [4:0]  wb_reg;
  logic        out_valid, overflow;
  logic [31:0] out_pc, out_value, commit_cnt;
  logic [4:0]  out_reg, level, high_water;
  logic [15:0] drop_cnt;
`ifdef WB_TRACE_TS_EN
  logic [31:0] out_ts;
`endif

  int n_checks = 0;
  int n_errors = 0;

  wb_trace_buffer #(.DEPTH(16), .AW(4), .SKIP_X0(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_en     (trace_en),
    .flush        (flush),
    .wb_have_inst (wb_have_inst),
    .wb_ena       (wb_ena),
    .wb_pc        (wb_pc),
    .wb_reg       (wb_reg),
    .wb_value     (wb_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_reg      (out_reg),
    .out_value    (out_value),
    .level        (level),
    .high_water   (high_water),
    .commit_cnt   (commit_cnt),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
`ifdef WB_TRACE_TS_EN
    ,
    .out_ts       (out_ts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] v);
    wb_have_inst = 1'b1;
    wb_ena       = 1'b1;
    wb_pc        = pc;
    wb_reg       = r;
    wb_value     = v;
  endtask

  task automatic idle();
    wb_have_inst = 1'b0;
    wb_ena       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; trace_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    wb_pc = '0; wb_reg = '0; wb_value = '0;
    idle();
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_commit", commit_cnt, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // --- three commits drained as they arrive, one cycle later each ---
    trace_en = 1'b1; out_ready = 1'b1;
    set_commit(32'h0, 5'd5, 32'd1); step();
    check("t1_valid0", 32'(out_valid), 32'd1);
    check("t1_pc0", out_pc, 32'h0);
    check("t1_reg0", 32'(out_reg), 32'd5);
    check("t1_val0", out_value, 32'd1);
    set_commit(32'h4, 5'd6, 32'd2); step();
    check("t1_pc1", out_pc, 32'h4);
    check("t1_val1", out_value, 32'd2);
    check("t1_level1", 32'(level), 32'd1);
    set_commit(32'h8, 5'd7, 32'd3); step();
    check("t1_pc2", out_pc, 32'h8);
    check("t1_reg2", 32'(out_reg), 32'd7);
    check("t1_val2", out_value, 32'd3);
    idle(); step();
    check("t1_empty", 32'(out_valid), 32'd0);
    check("t1_level", 32'(level), 32'd0);
    check("t1_commit", commit_cnt, 32'd3);
    check("t1_hw", 32'(high_water), 32'd1);

    // --- non-qualifying commits: x0, wb_ena=0, trace_en=0 ---
    set_commit(32'h20, 5'd0, 32'd9); step();
    check("t2_x0_valid", 32'(out_valid), 32'd0);
    set_commit(32'h24, 5'd3, 32'd9); wb_ena = 1'b0; step();
    check("t2_ena_valid", 32'(out_valid), 32'd0);
    set_commit(32'h28, 5'd3, 32'd9); trace_en = 1'b0; step();
    check("t2_en_valid", 32'(out_valid), 32'd0);
    check("t2_commit", commit_cnt, 32'd3);
    trace_en = 1'b1;

    // --- 20 commits with the sink stalled: 16 stored, 4 dropped ---
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_commit(32'h100 + 32'(4 * i), 5'(1 + i), 32'(100 + i));
      step();
    end
    idle();
    check("t3_level", 32'(level), 32'd16);
    check("t3_hw", 32'(high_water), 32'd16);
    check("t3_drop", 32'(drop_cnt), 32'd4);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_commit", commit_cnt, 32'd23);
    check("t3_head_val", out_value, 32'd100);
    check("t3_head_pc", out_pc, 32'h100);

    // --- full FIFO, commit with simultaneous pop: no drop ---
    out_ready = 1'b1;
    set_commit(32'h400, 5'd9, 32'd200); step();
    idle();
    check("t4_level", 32'(level), 32'd16);
    check("t4_drop", 32'(drop_cnt), 32'd4);
    check("t4_head", out_value, 32'd101);
    check("t4_commit", commit_cnt, 32'd24);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t4_drain%0d", i), out_value, 32'(101 + i));
      step();
    end
    check("t4_last_val", out_value, 32'd200);
    check("t4_last_pc", out_pc, 32'h400);
    step();
    check("t4_empty", 32'(out_valid), 32'd0);

    // --- flush with a same-cycle commit ---
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_commit(32'h500 + 32'(4 * i), 5'd2, 32'(300 + i));
      step();
    end
    check("t5_level", 32'(level), 32'd5);
    set_commit(32'h600, 5'd4, 32'd400); flush = 1'b1; step();
    idle(); flush = 1'b0;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_level0", 32'(level), 32'd0);
    check("t5_hw", 32'(high_water), 32'd0);
    check("t5_drop", 32'(drop_cnt), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_commit", commit_cnt, 32'd30);

    // --- asynchronous reset mid-drain ---
    for (int i = 0; i < 3; i++) begin
      set_commit(32'h700 + 32'(4 * i), 5'd8, 32'(500 + i));
      step();
    end
    idle(); out_ready = 1'b1; step();
    check("t6_pre_level", 32'(level), 32'd2);
    check("t6_pre_val", out_value, 32'd501);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_pc", out_pc, 32'd0);
    check("t6_reg", 32'(out_reg), 32'd0);
    check("t6_val", out_value, 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_hw", 32'(high_water), 32'd0);
    check("t6_commit", commit_cnt, 32'd0);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;

`ifdef WB_TRACE_TS_EN
    // Edges after reset release are numbered 0,1,2,...; capture at 3 and 7.
    step(); step(); step();
    set_commit(32'h800, 5'd1, 32'd1); step(); idle();
    step(); step(); step();
    set_commit(32'h804, 5'd1, 32'd2); step(); idle();
    check("ts_first", out_ts, 32'd3);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("ts_second", out_ts, 32'd7);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
